// File: rtl/ram_req_arbiter.sv
// Turns per-port bus edges into latched requests and serves them, one at a time, over a
// toggle-handshake SDRAM port. Define RAMARB_PRIORITY_EN to give port 0 fixed priority.

module ram_req_arbiter_port #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          cs,
  input  logic          oe,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  input  logic          issue_i,
  output logic          pend_o,
  output logic [AW-1:0] slot_addr_o,
  output logic          slot_we_o,
  output logic [7:0]    slot_din_o
);
  logic          rd_q, wr_q, prev_rd_q, prev_wr_q, pend_q, slot_we_q, trig;
  logic [AW-1:0] addr_q, prev_addr_q, slot_addr_q;
  logic [7:0]    din_q, slot_din_q;

  // Bus is registered once before edge detection; the history stage sits behind it.
  assign trig = (rd_q & ~prev_rd_q) | (wr_q & ~prev_wr_q) | (rd_q & (addr_q != prev_addr_q));

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      prev_rd_q   <= 1'b0;
      prev_wr_q   <= 1'b0;
      addr_q      <= '0;
      prev_addr_q <= '0;
      din_q       <= '0;
      pend_q      <= 1'b0;
      slot_addr_q <= '0;
      slot_we_q   <= 1'b0;
      slot_din_q  <= '0;
    end else begin
      rd_q        <= cs & oe;
      wr_q        <= cs & we;
      addr_q      <= addr;
      din_q       <= din;
      prev_rd_q   <= rd_q;
      prev_wr_q   <= wr_q;
      prev_addr_q <= addr_q;
      // A trigger coinciding with an issue re-arms: the issue already took the old slot.
      if (trig) begin
        pend_q      <= 1'b1;
        slot_addr_q <= addr_q;
        slot_we_q   <= wr_q;
        slot_din_q  <= din_q;
      end else if (issue_i) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign pend_o      = pend_q;
  assign slot_addr_o = slot_addr_q;
  assign slot_we_o   = slot_we_q;
  assign slot_din_o  = slot_din_q;
endmodule

module ram_req_arbiter #(
  parameter int NPORTS = 2,
  parameter int AW     = 16
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic [NPORTS-1:0]    cs,
  input  logic [NPORTS-1:0]    oe,
  input  logic [NPORTS-1:0]    we,
  input  logic [NPORTS*AW-1:0] addr,
  input  logic [NPORTS*8-1:0]  din,
  output logic [NPORTS*8-1:0]  dout,
  output logic [NPORTS-1:0]    busy,
  output logic                 mem_req,
  input  logic                 mem_ack,
  output logic [AW-1:0]        mem_a,
  output logic                 mem_we,
  output logic [1:0]           mem_ds,
  output logic [15:0]          mem_d,
  input  logic [15:0]          mem_q
);
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e                     state_q, state_d;
  logic [PW-1:0]              last_q, last_d, grant_q, grant_d, sel, cand;
  logic                       found, upd_ptr;
  int                         idx;
  logic [NPORTS-1:0]          pend, issue, slot_we;
  logic [NPORTS-1:0][AW-1:0]  slot_addr;
  logic [NPORTS-1:0][7:0]     slot_din, dout_q, dout_d;
  logic                       req_q, req_d, we_q, we_d;
  logic [AW-1:0]              a_q, a_d;
  logic [1:0]                 ds_q, ds_d;
  logic [15:0]                d_q, d_d;

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    ram_req_arbiter_port #(.AW(AW)) u_port (
      .clk        (clk),
      .res_n      (res_n),
      .cs         (cs[i]),
      .oe         (oe[i]),
      .we         (we[i]),
      .addr       (addr[i*AW +: AW]),
      .din        (din[i*8 +: 8]),
      .issue_i    (issue[i]),
      .pend_o     (pend[i]),
      .slot_addr_o(slot_addr[i]),
      .slot_we_o  (slot_we[i]),
      .slot_din_o (slot_din[i])
    );
    assign busy[i] = pend[i] | ((state_q == S_WAIT) && (grant_q == PW'(i)));
  end

  // Round-robin search starts one past the last grant and wraps at NPORTS-1.
  always_comb begin
    sel     = last_q;
    cand    = '0;
    idx     = 0;
    found   = 1'b0;
    upd_ptr = 1'b1;
    for (int k = 1; k <= NPORTS; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NPORTS) idx = idx - NPORTS;
      cand = PW'(idx);
      if (!found && pend[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
`ifdef RAMARB_PRIORITY_EN
    // Port 0 jumps the queue without disturbing the rotation among the others.
    if (pend[0]) begin
      sel     = '0;
      upd_ptr = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    req_d   = req_q;
    we_d    = we_q;
    a_d     = a_q;
    ds_d    = ds_q;
    d_d     = d_q;
    dout_d  = dout_q;
    issue   = '0;
    case (state_q)
      S_IDLE: begin
        if (|pend) begin
          issue[sel] = 1'b1;
          grant_d    = sel;
          if (upd_ptr) last_d = sel;
          a_d     = slot_addr[sel];
          we_d    = slot_we[sel];
          d_d     = {slot_din[sel], slot_din[sel]};
          ds_d    = slot_we[sel] ? (slot_addr[sel][0] ? 2'b10 : 2'b01) : 2'b11;
          req_d   = ~req_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack == req_q) begin
          if (!we_q) dout_d[grant_q] = a_q[0] ? mem_q[15:8] : mem_q[7:0];
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= S_IDLE;
      last_q  <= PW'(NPORTS - 1);
      grant_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      a_q     <= '0;
      ds_q    <= 2'b11;
      d_q     <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      req_q   <= req_d;
      we_q    <= we_d;
      a_q     <= a_d;
      ds_q    <= ds_d;
      d_q     <= d_d;
      dout_q  <= dout_d;
    end
  end

  assign dout    = dout_q;
  assign mem_req = req_q;
  assign mem_we  = we_q;
  assign mem_a   = a_q;
  assign mem_ds  = ds_q;
  assign mem_d   = d_q;
endmodule
